// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter sharing one 4-way routed resource among four
// requesters, with a bounded hold time for an owner while others are waiting.
//
// Ports:
//   clk    in   1  clock, all state updates on the rising edge
//   reset  in   1  synchronous, active-high reset
//   req    in   4  request per requester, held high while the resource is wanted
//   gnt    out  4  one-hot grant (registered), 4'b0000 when idle
//   sel    out  2  encoded owner index for the dmux4way/mux4way select (registered)
//   busy   out  1  high whenever a grant is active (registered, equals |gnt)
//
// Parameter:
//   MAX_HOLD  maximum consecutive grant cycles for one owner while contended (>= 1)

module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [3:0] cand_c;
  logic [1:0] idx_c;
  logic [1:0] win_c;
  logic       found_c;
  logic       release_c;
  logic       preempt_c;
  logic       take_c;
  logic       drop_c;

  // Winner search: candidates exclude the current owner while granted; the scan
  // runs from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    cand_c  = req;
    idx_c   = 2'd0;
    win_c   = ptr;
    found_c = 1'b0;
    if (state == GRANT) begin
      cand_c = req & ~gnt;
    end
    for (int i = 3; i >= 0; i--) begin
      idx_c = ptr + 2'(i);
      if (cand_c[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Grant decisions for the coming edge.
  always_comb begin
    release_c = (state == GRANT) && !req[sel];
    preempt_c = (state == GRANT) && req[sel] && (hold_cnt == HOLD_LAST) && found_c;
    take_c    = found_c && ((state == IDLE) || release_c || preempt_c);
    drop_c    = release_c && !found_c;
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
    end else if (take_c) begin
      state    <= GRANT;
      gnt      <= 4'b0001 << win_c;
      sel      <= win_c;
      busy     <= 1'b1;
      ptr      <= win_c + 2'd1;
      hold_cnt <= '0;
    end else if (drop_c) begin
      // sel deliberately keeps the last owner so the downstream mux stays stable.
      state <= IDLE;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
    end else if ((state == GRANT) && (hold_cnt != HOLD_LAST)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scoreboard bench for rr_arbiter4, one instance with
// MAX_HOLD=4 and one with MAX_HOLD=1.

module tb_rr_arbiter4;

  logic       clk;
  logic       reset4, reset1;
  logic [3:0] req4, req1;
  logic [3:0] gnt4, gnt1;
  logic [1:0] sel4, sel1;
  logic       busy4, busy1;

  int n_checks;
  int n_fail;

  typedef struct {
    int         dut;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .req   (req4),
    .gnt   (gnt4),
    .sel   (sel4),
    .busy  (busy4)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .req   (req1),
    .gnt   (gnt1),
    .sel   (sel1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int d, input logic [3:0] g, input logic [1:0] s, input string t);
    exp_t e;
    e.dut  = d;
    e.gnt  = g;
    e.sel  = s;
    e.busy = |g;
    e.tag  = t;
    sb.push_back(e);
  endtask

  task automatic check_inv(input string t, input logic [3:0] g, input logic [1:0] s, input logic b);
    logic [3:0] dec;
    dec = 4'b0001 << s;
    n_checks++;
    assert ((g & (g - 4'd1)) === 4'b0000) else begin
      n_fail++;
      $error("FAIL %s onehot0 observed gnt=%b required one-hot or zero", t, g);
    end
    n_checks++;
    assert (b === (|g)) else begin
      n_fail++;
      $error("FAIL %s busy observed=%b required=%b", t, b, |g);
    end
    n_checks++;
    assert (!b || (g === dec)) else begin
      n_fail++;
      $error("FAIL %s sel_match observed gnt=%b sel=%0d required gnt=%b", t, g, s, dec);
    end
  endtask

  // Advance one edge, sample 1 time unit later, check invariants, drain scoreboard.
  task automatic tick();
    exp_t       e;
    logic [3:0] og;
    logic [1:0] os;
    logic       ob;
    @(posedge clk);
    #1;
    check_inv("inv4", gnt4, sel4, busy4);
    check_inv("inv1", gnt1, sel1, busy1);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      og = (e.dut == 1) ? gnt1 : gnt4;
      os = (e.dut == 1) ? sel1 : sel4;
      ob = (e.dut == 1) ? busy1 : busy4;
      n_checks++;
      assert (og === e.gnt) else begin
        n_fail++;
        $error("FAIL %s gnt observed=%b expected=%b", e.tag, og, e.gnt);
      end
      n_checks++;
      assert (os === e.sel) else begin
        n_fail++;
        $error("FAIL %s sel observed=%0d expected=%0d", e.tag, os, e.sel);
      end
      n_checks++;
      assert (ob === e.busy) else begin
        n_fail++;
        $error("FAIL %s busy observed=%b expected=%b", e.tag, ob, e.busy);
      end
    end
  endtask

  task automatic step4(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input string t);
    req4 = r;
    push(4, g, s, t);
    tick();
  endtask

  task automatic step1(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input string t);
    req1 = r;
    push(1, g, s, t);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset4   = 1'b1;
    reset1   = 1'b1;
    req4     = 4'b1111;
    req1     = 4'b0110;

    // Reset held with all requests high.
    step4(4'b1111, 4'b0000, 2'd0, "reset_a");
    step4(4'b1111, 4'b0000, 2'd0, "reset_b");

    // Release reset: first grant to 0, then 4-cycle rotation.
    reset4 = 1'b0;
    for (int o = 0; o < 4; o++) begin
      for (int n = 0; n < 4; n++) begin
        step4(4'b1111, 4'b0001 << o, 2'(o), $sformatf("rot_o%0d_n%0d", o, n));
      end
    end
    step4(4'b1111, 4'b0001, 2'd0, "rot_wrap");

    // Owner 0 with req 0011, then release handoff to 1.
    step4(4'b0011, 4'b0001, 2'd0, "handoff_hold");
    step4(4'b0010, 4'b0010, 2'd1, "handoff");

    // Back to idle, then a single uncontended requester.
    step4(4'b0000, 4'b0000, 2'd1, "idle_sel_keep");
    step4(4'b0100, 4'b0100, 2'd2, "single_grant");
    for (int n = 0; n < 10; n++) begin
      step4(4'b0100, 4'b0100, 2'd2, $sformatf("single_hold%0d", n));
    end
    step4(4'b0000, 4'b0000, 2'd2, "single_release");

    // Pointer fairness around the wrap.
    step4(4'b1000, 4'b1000, 2'd3, "fair_g3");
    step4(4'b1001, 4'b1000, 2'd3, "fair_hold3");
    step4(4'b0001, 4'b0001, 2'd0, "fair_wrap0");
    step4(4'b0000, 4'b0000, 2'd0, "fair_idle");
    step4(4'b1001, 4'b1000, 2'd3, "fair_ptr1");

    // Mid-grant reset.
    step4(4'b0010, 4'b0010, 2'd1, "mid_g1");
    reset4 = 1'b1;
    step4(4'b0010, 4'b0000, 2'd0, "mid_reset");
    reset4 = 1'b0;
    step4(4'b0000, 4'b0000, 2'd0, "post_reset_idle");

    // MAX_HOLD=1: alternate every cycle under contention.
    step1(4'b0110, 4'b0000, 2'd0, "mh1_reset");
    reset1 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if ((n % 2) == 0) step1(4'b0110, 4'b0010, 2'd1, $sformatf("mh1_alt%0d", n));
      else              step1(4'b0110, 4'b0100, 2'd2, $sformatf("mh1_alt%0d", n));
    end
    // Owner 2 releases, 1 takes over and then holds without competition.
    step1(4'b0010, 4'b0010, 2'd1, "mh1_release");
    for (int n = 0; n < 3; n++) begin
      step1(4'b0010, 4'b0010, 2'd1, $sformatf("mh1_solo%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
